// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store stage driving a req/ack data-memory port.
// Optional macro LSU_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYCLES cycles without ack.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        access_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] read_data_q, read_data_d;
  logic        access_err_q, access_err_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;

  logic        start, legal, aligned;
  logic [1:0]  lo;
  logic [3:0]  strb;
  logic [31:0] wdata, load_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign start = memRead | memWrite;
  assign lo    = ALUResult[1:0];
  assign stall = ((state_q == IDLE) && start) || (state_q == WAIT);

  // Stores are decoded whenever memWrite is set, so a read+write pair is a store.
  always_comb begin
    aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   aligned = ~lo[0];
      2'b10:   aligned = (lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    if (memWrite) legal = funct3 inside {3'b000, 3'b001, 3'b010};
    else          legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3[1:0])
      2'b00: begin
        strb  = 4'b0001 << lo;
        wdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << lo;
        wdata = {2{writeData[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = writeData;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{lo_q, 3'b000} +: 8];
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_fmt = {24'd0, ld_byte};
      3'b101:  load_fmt = {16'd0, ld_half};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    read_data_d  = read_data_q;
    access_err_d = access_err_q;
    f3_d         = f3_q;
    lo_d         = lo_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal && aligned) begin
            state_d     = WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = memWrite;
            mem_addr_d  = {ALUResult[31:2], 2'b00};
            mem_wdata_d = wdata;
            mem_wstrb_d = memWrite ? strb : 4'b0000;
            f3_d        = funct3;
            lo_d        = lo;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            state_d      = DONE;
            access_err_d = 1'b1;
            read_data_d  = '0;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          access_err_d = 1'b0;
          read_data_d  = mem_we_q ? 32'd0 : load_fmt;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          access_err_d = 1'b1;
          read_data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      read_data_q  <= '0;
      access_err_q <= 1'b0;
      f3_q         <= '0;
      lo_q         <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      read_data_q  <= read_data_d;
      access_err_q <= access_err_d;
      f3_q         <= f3_d;
      lo_q         <= lo_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign readData   = read_data_q;
  assign access_err = access_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit.
// Directed vector table, reset/timeout sequences, and random accesses against a reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, writeData;
  logic [31:0] readData;
  logic        stall, access_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .ALUResult(ALUResult), .writeData(writeData),
    .readData(readData), .stall(stall), .access_err(access_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_we;
    int          exp_stalls;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: access size in bytes, legality, and lane arithmetic.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_legal(input logic store, input logic [2:0] f3, input logic [31:0] addr);
    logic ok_f3;
    ok_f3 = store ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return ok_f3 && ((addr % nbytes(f3)) == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    int    n;
    longint v;
    n = nbytes(f3);
    v = longint'(rdata >> ((addr % 4) * 8)) & ((64'd1 << (8 * n)) - 1);
    if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic vec_t model_vec(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     input logic [31:0] rdata, input int delay);
    vec_t v;
    int   n;
    logic lg;
    n = nbytes(f3);
    lg = model_legal(wr, f3, addr);
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata; v.delay = delay;
    v.exp_req    = lg;
    v.exp_err    = !lg;
    v.exp_rdata  = (lg && !wr) ? model_load(f3, addr, rdata) : 32'd0;
    v.exp_addr   = addr & ~32'h3;
    v.exp_strb   = wr ? 4'(((1 << n) - 1) << (addr % 4)) : 4'd0;
    for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    v.exp_we     = wr;
    v.exp_stalls = lg ? delay + 2 : 1;
    return v;
  endfunction

  // Call just after a rising edge; runs one instruction until DONE or max_cyc cycles.
  task automatic verify(input string tag, input vec_t v, input int max_cyc, input logic exp_done);
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_strb;
    logic        o_err, o_req, o_we, o_done, o_stable, o_req_done;
    int          o_stalls, waited;
    o_rdata = 0; o_addr = 0; o_wdata = 0; o_strb = 0; o_err = 0; o_req = 0; o_we = 0;
    o_done = 0; o_stable = 1; o_req_done = 0; o_stalls = 0; waited = 0;
    memRead = v.rd; memWrite = v.wr; funct3 = v.f3; ALUResult = v.addr;
    writeData = v.wd; mem_rdata = v.rdata;
    for (int c = 0; c < max_cyc && !o_done; c++) begin
      mem_ack = mem_req && (waited == v.delay);
      if (mem_req) waited++;
      @(negedge clk);
      if (stall) o_stalls++;
      else begin
        o_done = 1; o_rdata = readData; o_err = access_err; o_req_done = mem_req;
        memRead = 0; memWrite = 0;
      end
      if (mem_req) begin
        if (!o_req) begin
          o_addr = mem_addr; o_strb = mem_wstrb; o_wdata = mem_wdata; o_we = mem_we;
        end else if (o_addr !== mem_addr || o_strb !== mem_wstrb || o_wdata !== mem_wdata || o_we !== mem_we) begin
          o_stable = 0;
        end
        o_req = 1;
      end
      @(posedge clk); #1;
      mem_ack = 0;
    end
    memRead = 0; memWrite = 0;
    check({tag, "_done"}, 32'(o_done), 32'(exp_done));
    check({tag, "_stalls"}, o_stalls, exp_done ? v.exp_stalls : max_cyc);
    if (exp_done) begin
      check({tag, "_rdata"}, o_rdata, v.exp_rdata);
      check({tag, "_err"}, 32'(o_err), 32'(v.exp_err));
      check({tag, "_req_seen"}, 32'(o_req), 32'(v.exp_req));
      check({tag, "_req_in_done"}, 32'(o_req_done), 32'd0);
    end
    if (v.exp_req && o_req) begin
      check({tag, "_addr"}, o_addr, v.exp_addr);
      check({tag, "_strb"}, 32'(o_strb), 32'(v.exp_strb));
      check({tag, "_we"}, 32'(o_we), 32'(v.exp_we));
      check({tag, "_stable"}, 32'(o_stable), 32'd1);
      if (v.exp_we) check({tag, "_wdata"}, o_wdata, v.exp_wdata);
    end
  endtask

  vec_t vecs[13];
  vec_t rv;

  initial begin
    //          rd wr f3    addr          wd            rdata         dly exp_rdata     err req addr          strb     wdata         we st
    vecs[0]  = '{1, 0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 1, 32'h100, 4'b0000, 32'h0,        0, 3};
    vecs[1]  = '{1, 0, 3'd0, 32'h103, 32'h0,        32'h80112233, 0, 32'hFFFFFF80, 0, 1, 32'h100, 4'b0000, 32'h0,        0, 2};
    vecs[2]  = '{1, 0, 3'd4, 32'h103, 32'h0,        32'h80112233, 0, 32'h00000080, 0, 1, 32'h100, 4'b0000, 32'h0,        0, 2};
    vecs[3]  = '{1, 0, 3'd5, 32'h102, 32'h0,        32'h80112233, 0, 32'h00008011, 0, 1, 32'h100, 4'b0000, 32'h0,        0, 2};
    vecs[4]  = '{1, 0, 3'd1, 32'h102, 32'h0,        32'h80112233, 2, 32'hFFFF8011, 0, 1, 32'h100, 4'b0000, 32'h0,        0, 4};
    vecs[5]  = '{0, 1, 3'd1, 32'h206, 32'h0000ABCD, 32'h0,        0, 32'h0,        0, 1, 32'h204, 4'b1100, 32'hABCDABCD, 1, 2};
    vecs[6]  = '{0, 1, 3'd0, 32'h201, 32'h123456EF, 32'h0,        0, 32'h0,        0, 1, 32'h200, 4'b0010, 32'hEFEFEFEF, 1, 2};
    vecs[7]  = '{0, 1, 3'd2, 32'h300, 32'h11223344, 32'h0,        2, 32'h0,        0, 1, 32'h300, 4'b1111, 32'h11223344, 1, 4};
    vecs[8]  = '{1, 0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0, 1};
    vecs[9]  = '{1, 0, 3'd3, 32'h100, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0, 1};
    vecs[10] = '{0, 1, 3'd4, 32'h100, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0, 1};
    vecs[11] = '{0, 1, 3'd1, 32'h203, 32'h0,        32'h0,        0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0, 1};
    vecs[12] = '{1, 1, 3'd0, 32'h000, 32'h0000005A, 32'hFFFFFFFF, 0, 32'h0,        0, 1, 32'h000, 4'b0001, 32'h5A5A5A5A, 1, 2};

    rst_n = 0; memRead = 0; memWrite = 0; funct3 = 0; ALUResult = 0; writeData = 0;
    mem_rdata = 0; mem_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_readData", readData, 32'd0);
    check("rst_err", 32'(access_err), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_strb", 32'(mem_wstrb), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) verify($sformatf("vec%0d", i), vecs[i], 20, 1'b1);

    // Reset in the middle of a WAIT, then a stray ack afterwards.
    memWrite = 1; funct3 = 3'd2; ALUResult = 32'h400; writeData = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("mid_rst_req_before", 32'(mem_req), 32'd1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("mid_rst_req_async", 32'(mem_req), 32'd0);
    memWrite = 0;
    #1;
    check("mid_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    check("post_rst_ack_req", 32'(mem_req), 32'd0);
    check("post_rst_ack_stall", 32'(stall), 32'd0);
    check("post_rst_ack_rdata", readData, 32'd0);
    check("post_rst_ack_err", 32'(access_err), 32'd0);
    check("post_rst_ack_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
    rv = model_vec(0, 1, 3'd2, 32'h500, 32'h1, 32'h0, 1000);
    rv.exp_err = 1; rv.exp_stalls = 5;
    verify("timeout", rv, 20, 1'b1);
    rv = model_vec(1, 0, 3'd2, 32'h504, 32'h0, 32'h13572468, 3);
    verify("ack_at_timeout", rv, 20, 1'b1);
`else
    rv = model_vec(1, 0, 3'd2, 32'h500, 32'h0, 32'h0, 100000);
    verify("no_timeout", rv, 55, 1'b0);
    check("no_timeout_still_stalled", 32'(stall), 32'd1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      rv = model_vec(kind != 1, kind != 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                     $urandom_range(0, 3));
      verify($sformatf("rnd%0d", i), rv, 20, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RISC-V core.
- Takes ALUResult as the effective address and rs2 data as store data, and runs byte/half/word loads and stores over a req/ack data-memory port.
- Sign/zero-extends load data for writeback.
- Holds the core with a stall signal until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16, max WAIT cycles before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- memRead  input  1  current instruction is a load.
- memWrite  input  1  current instruction is a store.
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ALUResult  input  32  effective byte address.
- writeData  input  32  store data (rs2).
- readData  output  32  extended load result, valid in DONE.
- stall  output  1  hold PC/instruction while 1.
- access_err  output  1  misaligned/illegal/timeout flag, valid in DONE.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word-aligned address, {ALUResult[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte enables.
- mem_rdata  input  32  memory read word.
- mem_ack  input  1  1-cycle completion pulse from memory.

Behaviour:
- start = memRead | memWrite.
- Write takes priority: if both memRead and memWrite are 1, treat as a store.
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, mem_wstrb, access_err = 0; readData, mem_addr, mem_wdata = 0. Asserting reset during WAIT drops mem_req immediately; any later ack is ignored.
- FSM states: IDLE, WAIT, DONE.
- stall = (state==IDLE & start) | (state==WAIT). stall is combinational and 0 in DONE.
- IDLE, start, legal and aligned: latch addr, wdata, strb and we; go to WAIT with mem_req=1 registered.
- Alignment rule: h needs addr[0]=0; w needs addr[1:0]=00.
- IDLE, start, misaligned, or funct3 not in the legal set (loads: 000/001/010/100/101; stores: 000/001/010): no memory access; go to DONE with access_err=1 and readData=0.
- WAIT: hold mem_req and all mem_* outputs stable until mem_ack=1.
  - On ack: mem_req=0; for a load, register the formatted readData; for a store, readData=0. Go to DONE with access_err=0.
  - mem_ack seen in IDLE or DONE is ignored.
- DONE: one cycle; outputs stay valid; the core retires at this edge. Always return to IDLE. A start on the next instruction is evaluated in IDLE.
- Minimum latency: 3 cycles (IDLE, WAIT with ack in its first cycle, DONE).
- Store strobes:
  - sb: strb = 0001<<addr[1:0]; wdata = {4{wd[7:0]}}.
  - sh: strb = 0011<<addr[1:0]; wdata = {2{wd[15:0]}}.
  - sw: strb = 1111; wdata = wd.
- Loads: mem_wstrb=0. Select the byte/half by addr[1:0]. b/h sign-extend from bit 7/15; bu/hu zero-extend.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to WAIT, incremented each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, drop mem_req and go to DONE with access_err=1 and readData=0.
  - An ack in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; WAIT persists indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- lw @0x100, memory acks 2 cycles after req with rdata=0xDEADBEEF -> mem_addr=0x100, mem_wstrb=0000, stall=1 for 3 cycles, DONE readData=0xDEADBEEF, access_err=0.
- lb @0x103, rdata=0x80112233 -> readData=0xFFFFFF80. Same access as lbu -> 0x00000080. lhu @0x102 -> 0x00008011.
- sh @0x206, writeData=0x0000ABCD, ack in first WAIT cycle -> mem_addr=0x204, mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1; DONE reached 2 cycles after start.
- lw @0x101 -> no mem_req ever; next cycle DONE with access_err=1, readData=0. funct3=011 load behaves the same.
- Store in WAIT with no ack, rst_n pulsed low mid-WAIT -> mem_req=0 asynchronously, state IDLE; an ack arriving after reset release leaves outputs unchanged.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> DONE after 4 WAIT cycles with access_err=1. Without the macro, stall stays 1 for 50+ cycles.
